// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // A 1-bit operand still needs a 1-bit counter even though $clog2(1) is 0.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_addbit.sv
// Single full-adder cell; purely combinational, zero latency, no flow control.
module addbit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one addbit cell; done pulses WIDTH cycles after start is accepted.
// start is only sampled in IDLE; busy stays high through SHIFT and DONE, so starts then are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s;
  logic             cout;

  addbit u_addbit (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in order.
  generate
    if (WIDTH > 1) begin : g_acc_wide
      assign acc_nxt = {s, acc[WIDTH-1:1]};
    end else begin : g_acc_bit
      assign acc_nxt = s;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout_out <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_nxt;
          carry <= cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            sum      <= acc_nxt;
            cout_out <= cout;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance checked against a + b + cin.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout_out (cout_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .a_in     (a1),
    .b_in     (b1),
    .cin_in   (cin1),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
    .cout_out (cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One 8-bit transaction; optionally pokes a second start with new operands while busy.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input bit noise);
    logic [8:0] exp;
    int lat;
    int bcnt;
    bit got;
    exp = 9'(a) + 9'(b) + 9'(c);
    wait_idle();
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (noise && i == 2) begin
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd9);
    check({tag, "_result"}, 32'({cout_out, sum}), 32'(exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  task automatic run_add1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    int lat;
    bit got;
    exp = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check("w1_done_seen", 32'(got), 32'd1);
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_result", 32'({cout1, sum1}), 32'(exp));
    @(negedge clk);
    check("w1_busy_after", 32'(busy1), 32'd0);
  endtask

  initial begin
    int n;
    int last;
    int ndone;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'({cout_out, sum}), 32'd0);
    check("rst_w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_add("t1", 8'h0F, 8'h01, 1'b0, 1'b0);
    run_add("t2a", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_add("t2b", 8'hFF, 8'h00, 1'b1, 1'b0);
    run_add("t3", 8'hA5, 8'h5A, 1'b1, 1'b1);
    count_dones(15, n);
    check("t3_no_extra_done", 32'(n), 32'd0);
    check("t3_result_hold", 32'({cout_out, sum}), 32'h100);

    // Start held high: a fresh transaction every WIDTH+2 cycles.
    wait_idle();
    a_in = 8'd3; b_in = 8'd4; cin_in = 1'b0; start = 1'b1;
    last = -1; ndone = 0;
    for (int cyc = 0; cyc < 55; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("t4_sum", 32'({cout_out, sum}), 32'd7);
        if (last >= 0) check("t4_interval", 32'(cyc - last), 32'd10);
        last = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    check("t4_done_count", 32'(ndone), 32'd5);
    wait_idle();

    // Reset four cycles into SHIFT aborts the transaction.
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_result", 32'({cout_out, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(15, n);
    check("t5_no_done", 32'(n), 32'd0);
    run_add("t5b", 8'h80, 8'h80, 1'b0, 1'b0);

    run_add1(1'b1, 1'b1, 1'b1);
    run_add1(1'b1, 1'b0, 1'b0);
    run_add1(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_add("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
